// File: rtl/seq_checker.sv
// Self-check for the s[n] = s[n-2] + s[n-3] sequence generator: seeds from the stream,
// verifies each following sample, counts passes/errors and captures the first mismatch.
module seq_checker #(
  parameter int DataBus     = 32,
  parameter int SKIP        = 1,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 1
) (
  input  logic               clk_w,
  input  logic               reset_w,
  input  logic               clr_w,
  input  logic               seq_valid_w,
  input  logic [DataBus-1:0] seq_i_w,
  output logic [1:0]         state_o_w,
  output logic [CNT_W-1:0]   pass_cnt_w,
  output logic [CNT_W-1:0]   err_cnt_w,
  output logic               err_o_w,
  output logic [CNT_W-1:0]   err_idx_w,
  output logic [DataBus-1:0] err_exp_w,
  output logic [DataBus-1:0] err_got_w
);

  typedef enum logic [1:0] {
    ST_SKIP  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam state_t           INIT_STATE = (SKIP == 0) ? ST_SYNC : ST_SKIP;
  localparam int               SKIP_W     = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int               SKIP_LAST  = (SKIP > 0) ? SKIP - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic [1:0]         sync_q, sync_d;
  logic [DataBus-1:0] h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
  logic [CNT_W-1:0]   pass_q, pass_d, err_q, err_d, idx_q, idx_d;
  logic               err_flag_q, err_flag_d;
  logic [CNT_W-1:0]   err_idx_q, err_idx_d;
  logic [DataBus-1:0] err_exp_q, err_exp_d, err_got_q, err_got_d;
  logic [DataBus-1:0] exp_val;

  // Sum truncates to DataBus, so generator wrap-around is accepted as legal.
  assign exp_val = h2_q + h3_q;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    sync_d     = sync_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    h3_d       = h3_q;
    pass_d     = pass_q;
    err_d      = err_q;
    idx_d      = idx_q;
    err_flag_d = err_flag_q;
    err_idx_d  = err_idx_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;

    if (clr_w) begin
      state_d    = INIT_STATE;
      skip_d     = '0;
      sync_d     = '0;
      h1_d       = '0;
      h2_d       = '0;
      h3_d       = '0;
      pass_d     = '0;
      err_d      = '0;
      idx_d      = '0;
      err_flag_d = 1'b0;
      err_idx_d  = '0;
      err_exp_d  = '0;
      err_got_d  = '0;
    end else if (seq_valid_w) begin
      case (state_q)
        ST_SKIP: begin
          if (skip_q == SKIP_W'(SKIP_LAST)) begin
            state_d = ST_SYNC;
            skip_d  = '0;
          end else begin
            skip_d = skip_q + 1'b1;
          end
        end
        ST_SYNC: begin
          h3_d = h2_q;
          h2_d = h1_q;
          h1_d = seq_i_w;
          if (sync_q == 2'd2) begin
            state_d = ST_CHECK;
            sync_d  = '0;
          end else begin
            sync_d = sync_q + 1'b1;
          end
        end
        ST_CHECK: begin
          // idx tracks checked-sample order without saturation, for err_idx capture.
          idx_d = idx_q + 1'b1;
          if (seq_i_w == exp_val) begin
            if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
            h3_d = h2_q;
            h2_d = h1_q;
            h1_d = seq_i_w;
          end else begin
            if (err_q != CNT_MAX) err_d = err_q + 1'b1;
            if (!err_flag_q) begin
              err_flag_d = 1'b1;
              err_idx_d  = idx_q;
              err_exp_d  = exp_val;
              err_got_d  = seq_i_w;
            end
            sync_d  = '0;
            state_d = (STOP_ON_ERR != 0) ? ST_FAIL : ST_SYNC;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_w or posedge reset_w) begin
    if (reset_w) begin
      state_q    <= INIT_STATE;
      skip_q     <= '0;
      sync_q     <= '0;
      h1_q       <= '0;
      h2_q       <= '0;
      h3_q       <= '0;
      pass_q     <= '0;
      err_q      <= '0;
      idx_q      <= '0;
      err_flag_q <= 1'b0;
      err_idx_q  <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      sync_q     <= sync_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
      h3_q       <= h3_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      err_flag_q <= err_flag_d;
      err_idx_q  <= err_idx_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  assign state_o_w  = state_q;
  assign pass_cnt_w = pass_q;
  assign err_cnt_w  = err_q;
  assign err_o_w    = err_flag_q;
  assign err_idx_w  = err_idx_q;
  assign err_exp_w  = err_exp_q;
  assign err_got_w  = err_got_q;

endmodule

// File: tb/tb_seq_checker.sv
// Drives two checkers (32-bit halting, 8-bit resyncing) from one generator stream and
// scores their per-cycle outputs against a queued reference plus fixed scenario values.
module tb_seq_checker;

  logic        clk = 1'b0;
  logic        rst, clr, valid;
  logic [31:0] data;

  logic [1:0]  st_a, st_b;
  logic [15:0] pass_a, err_a, idx_a, pass_b, err_b, idx_b;
  logic        eo_a, eo_b;
  logic [31:0] exp_a, got_a;
  logic [7:0]  exp_b, got_b;

  seq_checker #(.DataBus(32), .SKIP(1), .CNT_W(16), .STOP_ON_ERR(1)) dut_a (
    .clk_w(clk), .reset_w(rst), .clr_w(clr), .seq_valid_w(valid), .seq_i_w(data),
    .state_o_w(st_a), .pass_cnt_w(pass_a), .err_cnt_w(err_a), .err_o_w(eo_a),
    .err_idx_w(idx_a), .err_exp_w(exp_a), .err_got_w(got_a));

  seq_checker #(.DataBus(8), .SKIP(1), .CNT_W(16), .STOP_ON_ERR(0)) dut_b (
    .clk_w(clk), .reset_w(rst), .clr_w(clr), .seq_valid_w(valid), .seq_i_w(data[7:0]),
    .state_o_w(st_b), .pass_cnt_w(pass_b), .err_cnt_w(err_b), .err_o_w(eo_b),
    .err_idx_w(idx_b), .err_exp_w(exp_b), .err_got_w(got_b));

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    int          skip;
    int          sync;
    logic [31:0] h1, h2, h3;
    int          pass, err, idx;
    bit          eo;
    int          eidx;
    logic [31:0] eexp, egot;
  } mdl_t;

  typedef struct {
    int st;
    int pass;
    int err;
    bit eo;
  } exp_t;

  mdl_t        ma, mb;
  exp_t        qa[$], qb[$];
  logic [31:0] gen[0:199];
  int          ptr;
  int          checks = 0;
  int          failures = 0;

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = 0; m.skip = 0; m.sync = 0;
    m.h1 = '0; m.h2 = '0; m.h3 = '0;
    m.pass = 0; m.err = 0; m.idx = 0;
    m.eo = 1'b0; m.eidx = 0; m.eexp = '0; m.egot = '0;
    return m;
  endfunction

  // Reference behaviour of one checker for one clock edge.
  function automatic mdl_t mstep(mdl_t m, bit c, bit v, logic [31:0] d, bit stop, logic [31:0] mask);
    logic [31:0] e;
    if (c) return mreset();
    if (!v) return m;
    d = d & mask;
    if (m.st == 0) begin
      m.skip++;
      if (m.skip == 1) m.st = 1;
    end else if (m.st == 1) begin
      m.h3 = m.h2; m.h2 = m.h1; m.h1 = d;
      m.sync++;
      if (m.sync == 3) begin m.st = 2; m.sync = 0; end
    end else if (m.st == 2) begin
      e = (m.h2 + m.h3) & mask;
      if (d == e) begin
        if (m.pass < 65535) m.pass++;
        m.h3 = m.h2; m.h2 = m.h1; m.h1 = d;
      end else begin
        if (m.err < 65535) m.err++;
        if (!m.eo) begin
          m.eo = 1'b1; m.eidx = m.idx & 16'hFFFF; m.eexp = e; m.egot = d;
        end
        m.sync = 0;
        m.st = stop ? 3 : 1;
      end
      m.idx++;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t ea, eb;
    checks++;
    assert (qa.size() == 1 && qb.size() == 1) else begin
      failures++;
      $error("[TB] FAIL scoreboard_depth observed=%0d expected=%0d", qa.size(), 1);
    end
    if (qa.size() > 0 && qb.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a_state", 64'(st_a), 64'(ea.st));
      chk("a_pass", 64'(pass_a), 64'(ea.pass));
      chk("a_err", 64'(err_a), 64'(ea.err));
      chk("a_err_o", 64'(eo_a), 64'(ea.eo));
      chk("b_state", 64'(st_b), 64'(eb.st));
      chk("b_pass", 64'(pass_b), 64'(eb.pass));
      chk("b_err", 64'(err_b), 64'(eb.err));
      chk("b_err_o", 64'(eo_b), 64'(eb.eo));
    end
  endtask

  task automatic applyStimulus(input bit c, input bit v, input logic [31:0] d);
    ma = mstep(ma, c, v, d, 1'b1, 32'hFFFF_FFFF);
    mb = mstep(mb, c, v, d, 1'b0, 32'h0000_00FF);
    qa.push_back('{ma.st, ma.pass, ma.err, ma.eo});
    qb.push_back('{mb.st, mb.pass, mb.err, mb.eo});
    clr = c; valid = v; data = d;
    @(posedge clk); #1;
    checkOutput();
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, gen[ptr]);
      ptr++;
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_a_state"}, 64'(st_a), 64'd0);
    chk({tag, "_a_pass"}, 64'(pass_a), 64'd0);
    chk({tag, "_a_err"}, 64'(err_a), 64'd0);
    chk({tag, "_a_err_o"}, 64'(eo_a), 64'd0);
    chk({tag, "_a_idx"}, 64'(idx_a), 64'd0);
    chk({tag, "_a_exp"}, 64'(exp_a), 64'd0);
    chk({tag, "_a_got"}, 64'(got_a), 64'd0);
    chk({tag, "_b_state"}, 64'(st_b), 64'd0);
    chk({tag, "_b_pass"}, 64'(pass_b), 64'd0);
    chk({tag, "_b_err_o"}, 64'(eo_b), 64'd0);
    chk({tag, "_b_exp"}, 64'(exp_b), 64'd0);
  endtask

  task automatic doReset();
    rst = 1'b1; clr = 1'b0; valid = 1'b0; data = '0;
    ma = mreset(); mb = mreset();
    @(posedge clk); #1;
    checkAllZero("reset");
    rst = 1'b0;
    ptr = 0;
  endtask

  initial begin
    gen[0] = 0; gen[1] = 0; gen[2] = 1; gen[3] = 1;
    for (int n = 4; n < 200; n++) gen[n] = gen[n-2] + gen[n-3];
    rst = 1'b1; clr = 1'b0; valid = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Clean run, then continue past the 8-bit wrap point.
    doReset();
    feed(20);
    chk("s1_a_pass16", 64'(pass_a), 64'd16);
    chk("s1_a_err0", 64'(err_a), 64'd0);
    chk("s1_b_pass16", 64'(pass_b), 64'd16);
    feed(20);
    chk("s4_b_pass36", 64'(pass_b), 64'd36);
    chk("s4_b_err0", 64'(err_b), 64'd0);
    chk("s4_b_err_o0", 64'(eo_b), 64'd0);

    // Corrupt sample #8 (4 -> 5), later corrupt sample #20 (114 -> 115).
    doReset();
    feed(8);
    applyStimulus(1'b0, 1'b1, 32'd5); ptr++;
    chk("s2_a_err_o", 64'(eo_a), 64'd1);
    chk("s2_a_exp", 64'(exp_a), 64'd4);
    chk("s2_a_got", 64'(got_a), 64'd5);
    chk("s2_a_idx", 64'(idx_a), 64'd4);
    chk("s2_a_fail", 64'(st_a), 64'd3);
    chk("s3_b_sync", 64'(st_b), 64'd1);
    feed(11);
    applyStimulus(1'b0, 1'b1, 32'd115); ptr++;
    feed(39);
    chk("s2_a_frozen_pass", 64'(pass_a), 64'd4);
    chk("s2_a_frozen_err", 64'(err_a), 64'd1);
    chk("s3_b_err2", 64'(err_b), 64'd2);
    chk("s3_b_pass48", 64'(pass_b), 64'd48);
    chk("s3_b_exp_kept", 64'(exp_b), 64'd4);
    chk("s3_b_got_kept", 64'(got_b), 64'd5);
    chk("s3_b_idx_kept", 64'(idx_b), 64'd4);

    // Valid gaps with garbage data on invalid cycles.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, gen[ptr]); ptr++;
      applyStimulus(1'b0, 1'b0, 32'hDEAD_BEEF);
    end
    chk("s5_a_pass16", 64'(pass_a), 64'd16);
    chk("s5_a_err0", 64'(err_a), 64'd0);
    chk("s5_b_pass16", 64'(pass_b), 64'd16);

    // Async reset between edges mid-check, then clear with valid high.
    doReset();
    feed(10);
    #3 rst = 1'b1;
    #1 checkAllZero("async");
    ma = mreset(); mb = mreset();
    @(posedge clk); #1;
    rst = 1'b0; ptr = 0;
    feed(10);
    applyStimulus(1'b1, 1'b1, 32'h1234_5678);
    checkAllZero("clear");
    ptr = 0;
    feed(20);
    chk("s6_a_pass16", 64'(pass_a), 64'd16);
    chk("s6_a_err0", 64'(err_a), 64'd0);
    chk("s6_b_err_o0", 64'(eo_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
